hdpldadapt_tx_pulse_stretch_cfg_ctrl: RTL and testbench
=======================================================

// Module: hdpldadapt_tx_pulse_stretch_cfg_ctrl
// PURPOSE
//  Sequences run-time changes to the TX pulse-stretch stage count (num_stages).
//  - Accepts a 4-phase config request.
//  - Waits for a quiet window on the raw frame/burst/wordslip/empty strobes.
//  - Applies the new count, then masks the stretched outputs while the stretch pipes refill.
//  Sits between the config register/AVMM side and the TX datapath pulse-stretch block.
// PARAMETERS
//  DEF_STAGES     3'd0  num_stages value driven out of reset
//  QUIET_CYCLES   8     consecutive quiet cycles required before apply (1..255)
//  SETTLE_CYCLES  8     cycles stretch_mask stays high after apply (>= max stage depth+1)
//  TIMEOUT_CYCLES 256   drain timeout, used only with the optional feature below
// PORTS
//  clk              in   1  clock
//  rst              in   1  synchronous, active-high reset
//  cfg_req          in   1  change request; level, 4-phase with cfg_ack
//  cfg_num_stages   in   3  requested stage count; stable while cfg_req=1
//  tx_frame_raw     in   1  activity monitor (unstretched)
//  burst_en_exe_raw in   1  activity monitor
//  wordslip_exe_raw in   1  activity monitor
//  rd_empty_raw     in   1  FIFO read-empty; 1 = nothing in flight
//  num_stages       out  3  drives pulse-stretch num_stages
//  stretch_mask     out  1  1 = downstream forces stretched strobes to 0 and empties to 1
//  cfg_busy         out  1  1 from request accept until return to IDLE
//  cfg_ack          out  1  4-phase ack
//  cfg_timeout      out  1  sticky drain-timeout flag (feature only; else tied 0)
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: num_stages=DEF_STAGES; stretch_mask=0; cfg_busy=0; cfg_ack=0; cfg_timeout=0; state=IDLE.
//  - quiet = ~(tx_frame_raw|burst_en_exe_raw|wordslip_exe_raw) & rd_empty_raw.
//  - FSM IDLE->DRAIN->APPLY->SETTLE->DONE->IDLE:
//    IDLE:   cfg_req=1 -> latch cfg_num_stages into new_q.
//            If new_q==num_stages, go DONE directly (no mask, no drain).
//            Else go DRAIN with qcnt=0, cfg_busy=1.
//    DRAIN:  quiet -> qcnt++; ~quiet -> qcnt=0.
//            qcnt reaching QUIET_CYCLES -> APPLY.
//            cfg_req=0 -> abort to IDLE: num_stages unchanged, no ack.
//    APPLY:  one cycle: num_stages<=new_q, stretch_mask<=1, scnt=0 -> SETTLE.
//    SETTLE: scnt++; scnt reaching SETTLE_CYCLES -> DONE with stretch_mask<=0.
//            cfg_req drop is ignored here; sequence completes.
//    DONE:   cfg_ack=1 while cfg_req=1. cfg_req=0 -> cfg_ack<=0, cfg_busy<=0 -> IDLE.
//  - Latency, always quiet, counted from the edge that first samples cfg_req=1 (edge 0):
//    num_stages updates after edge QUIET_CYCLES+1; cfg_ack rises after edge QUIET_CYCLES+SETTLE_CYCLES+2 (18 with defaults).
//  - num_stages changes only in APPLY and only while stretch_mask is high; it never glitches.
//  - Counters saturate; no wrap.
//  - cfg_num_stages changes while cfg_req=1 are ignored; new_q is latched only in IDLE.
//  - rst asserted in any state: IDLE and reset values after that edge.
//    In-progress change is lost; num_stages returns to DEF_STAGES.
// CONFIGURATION
//  - HDPLDADAPT_TX_STRETCH_CTRL_TIMEOUT_EN defined:
//    DRAIN also counts total cycles (tcnt).
//    tcnt reaching TIMEOUT_CYCLES forces APPLY regardless of quiet, and sets cfg_timeout=1.
//    cfg_timeout is sticky; it clears only on rst.
//  - Undefined: no tcnt; DRAIN waits indefinitely; cfg_timeout tied 0.
// TESTING
//  1. Reset, then idle -> num_stages=DEF_STAGES; mask, busy, ack and timeout all 0.
//  2. cfg_req=1, cfg_num_stages=3'd5, inputs quiet ->
//     num_stages=5 after edge 9; stretch_mask high edges 9-17; cfg_ack high after edge 18, until cfg_req drops.
//  3. As 2, but tx_frame_raw pulses at DRAIN qcnt=6 -> qcnt restarts; APPLY delayed 7 cycles; ack after edge 25.
//  4. Request with cfg_num_stages==num_stages -> cfg_ack next cycle; stretch_mask never asserts.
//  5. Drop cfg_req during DRAIN -> IDLE, num_stages unchanged, no ack. rst during SETTLE -> num_stages=DEF_STAGES, mask=0.
//  6. TIMEOUT_EN, rd_empty_raw=0 held -> APPLY after 256 DRAIN cycles; cfg_timeout=1 until rst.

Source files
------------

// File: rtl/hdpldadapt_tx_pulse_stretch_cfg_ctrl_if.sv
// Config request channel between the register/AVMM side (master) and the
// pulse-stretch sequencer (slave).
interface hdpldadapt_tx_pulse_stretch_cfg_ctrl_if;
  // Handshake: 4-phase. Master raises cfg_req with cfg_num_stages stable;
  // slave raises cfg_ack when done; master drops cfg_req; slave drops cfg_ack.
  logic       cfg_req;
  logic [2:0] cfg_num_stages;
  logic       cfg_busy;
  logic       cfg_ack;
  logic       cfg_timeout;

  modport master (
    output cfg_req,
    output cfg_num_stages,
    input  cfg_busy,
    input  cfg_ack,
    input  cfg_timeout
  );

  modport slave (
    input  cfg_req,
    input  cfg_num_stages,
    output cfg_busy,
    output cfg_ack,
    output cfg_timeout
  );
endinterface

// File: rtl/hdpldadapt_tx_pulse_stretch_cfg_ctrl.sv
// Sequences run-time changes of the TX pulse-stretch stage count: drain, apply, mask while refilling.
// Optional drain timeout enabled by defining HDPLDADAPT_TX_STRETCH_CTRL_TIMEOUT_EN.
module hdpldadapt_tx_pulse_stretch_cfg_ctrl #(
  parameter logic [2:0]  DEF_STAGES     = 3'd0,
  parameter int unsigned QUIET_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_frame_raw,
  input  logic       burst_en_exe_raw,
  input  logic       wordslip_exe_raw,
  input  logic       rd_empty_raw,
  output logic [2:0] num_stages,
  output logic       stretch_mask,
  output logic [2:0] state_dbg,
  hdpldadapt_tx_pulse_stretch_cfg_ctrl_if.slave cfg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] QUIET_LIM  = 8'(QUIET_CYCLES);
  localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] new_q, new_d;
  logic [2:0] num_q, num_d;
  logic       mask_q, mask_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic [7:0] qcnt_q, qcnt_d;
  logic [7:0] scnt_q, scnt_d;
  logic       quiet;

`ifdef HDPLDADAPT_TX_STRETCH_CTRL_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] tcnt_q, tcnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign quiet = ~(tx_frame_raw | burst_en_exe_raw | wordslip_exe_raw) & rd_empty_raw;

  always_comb begin
    state_d = state_q;
    new_d   = new_q;
    num_d   = num_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    ack_d   = ack_q;
    qcnt_d  = qcnt_q;
    scnt_d  = scnt_q;
`ifdef HDPLDADAPT_TX_STRETCH_CTRL_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg.cfg_req) begin
          new_d  = cfg.cfg_num_stages;
          busy_d = 1'b1;
          // No change requested: skip drain and mask, just handshake.
          if (cfg.cfg_num_stages == num_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            qcnt_d  = 8'd0;
`ifdef HDPLDADAPT_TX_STRETCH_CTRL_TIMEOUT_EN
            tcnt_d  = 16'd0;
`endif
          end
        end
      end
      S_DRAIN: begin
        if (!cfg.cfg_req) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (!quiet)                qcnt_d = 8'd0;
          else if (qcnt_q != 8'hFF)  qcnt_d = qcnt_q + 8'd1;
          if (qcnt_d == QUIET_LIM) state_d = S_APPLY;
`ifdef HDPLDADAPT_TX_STRETCH_CTRL_TIMEOUT_EN
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          if (tcnt_d == TIMEOUT_LIM) begin
            state_d   = S_APPLY;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      S_APPLY: begin
        num_d   = new_q;
        mask_d  = 1'b1;
        scnt_d  = 8'd0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // Request withdrawal is ignored: the new count is already live.
        if (scnt_q != 8'hFF) scnt_d = scnt_q + 8'd1;
        if (scnt_d == SETTLE_LIM) begin
          mask_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (cfg.cfg_req) begin
          ack_d = 1'b1;
        end else begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      new_q   <= DEF_STAGES;
      num_q   <= DEF_STAGES;
      mask_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      qcnt_q  <= 8'd0;
      scnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      new_q   <= new_d;
      num_q   <= num_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      qcnt_q  <= qcnt_d;
      scnt_q  <= scnt_d;
    end
  end

`ifdef HDPLDADAPT_TX_STRETCH_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign cfg.cfg_timeout = timeout_q;
`else
  assign cfg.cfg_timeout = 1'b0;
`endif

  assign num_stages   = num_q;
  assign stretch_mask = mask_q;
  assign cfg.cfg_busy = busy_q;
  assign cfg.cfg_ack  = ack_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_hdpldadapt_tx_pulse_stretch_cfg_ctrl.sv
// Directed table-driven bench for the pulse-stretch config sequencer.
module tb_hdpldadapt_tx_pulse_stretch_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_frame_raw, burst_en_exe_raw, wordslip_exe_raw, rd_empty_raw;
  logic [2:0] num_stages;
  logic       stretch_mask;
  logic [2:0] state_dbg;

  hdpldadapt_tx_pulse_stretch_cfg_ctrl_if cfg_if ();

  hdpldadapt_tx_pulse_stretch_cfg_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .tx_frame_raw     (tx_frame_raw),
    .burst_en_exe_raw (burst_en_exe_raw),
    .wordslip_exe_raw (wordslip_exe_raw),
    .rd_empty_raw     (rd_empty_raw),
    .num_stages       (num_stages),
    .stretch_mask     (stretch_mask),
    .state_dbg        (state_dbg),
    .cfg              (cfg_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [2:0] nst;
    logic       frame, burst, wslip, empty;
    int         cyc;
    logic [2:0] e_num;
    logic       e_mask, e_busy, e_ack;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One edge per count; outputs are read 1ns after the edge, inputs change there too.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input logic req, input logic [2:0] nst, input logic frame, input logic burst,
                     input logic wslip, input logic empty, input int cyc, input logic [2:0] e_num,
                     input logic e_mask, input logic e_busy, input logic e_ack, input string name);
    vec_t v;
    v.req = req; v.nst = nst; v.frame = frame; v.burst = burst; v.wslip = wslip; v.empty = empty;
    v.cyc = cyc; v.e_num = e_num; v.e_mask = e_mask; v.e_busy = e_busy; v.e_ack = e_ack; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_num, input logic e_mask,
                            input logic e_busy, input logic e_ack);
    check({tag, "_num"},  16'(num_stages),     16'(e_num));
    check({tag, "_mask"}, 16'(stretch_mask),   16'(e_mask));
    check({tag, "_busy"}, 16'(cfg_if.cfg_busy), 16'(e_busy));
    check({tag, "_ack"},  16'(cfg_if.cfg_ack),  16'(e_ack));
  endtask

  initial begin
    // Quiet change 0->5: apply at edge 9, mask edges 9..17, ack from edge 18.
    add(1, 3'd5, 0, 0, 0, 1, 1, 3'd0, 0, 1, 0, "t2_accept");
    add(1, 3'd5, 0, 0, 0, 1, 8, 3'd0, 0, 1, 0, "t2_drain");
    add(1, 3'd5, 0, 0, 0, 1, 1, 3'd5, 1, 1, 0, "t2_apply");
    add(1, 3'd5, 0, 0, 0, 1, 7, 3'd5, 1, 1, 0, "t2_settle");
    add(1, 3'd5, 0, 0, 0, 1, 1, 3'd5, 0, 1, 0, "t2_unmask");
    add(1, 3'd5, 0, 0, 0, 1, 1, 3'd5, 0, 1, 1, "t2_ack");
    add(1, 3'd5, 0, 0, 0, 1, 3, 3'd5, 0, 1, 1, "t2_ack_hold");
    add(0, 3'd5, 0, 0, 0, 1, 1, 3'd5, 0, 0, 0, "t2_release");
    // Same value: ack next cycle, never masked.
    add(1, 3'd5, 0, 0, 0, 1, 1, 3'd5, 0, 1, 0, "t4_accept");
    add(1, 3'd5, 0, 0, 0, 1, 1, 3'd5, 0, 1, 1, "t4_ack");
    add(0, 3'd5, 0, 0, 0, 1, 1, 3'd5, 0, 0, 0, "t4_release");
    // Frame pulse at qcnt=6 restarts the window: apply at edge 16, ack at 25.
    add(1, 3'd2, 0, 0, 0, 1, 7, 3'd5, 0, 1, 0, "t3_drain");
    add(1, 3'd2, 1, 0, 0, 1, 1, 3'd5, 0, 1, 0, "t3_frame");
    add(1, 3'd2, 0, 0, 0, 1, 8, 3'd5, 0, 1, 0, "t3_redrain");
    add(1, 3'd2, 0, 0, 0, 1, 1, 3'd2, 1, 1, 0, "t3_apply");
    add(1, 3'd2, 0, 0, 0, 1, 7, 3'd2, 1, 1, 0, "t3_settle");
    add(1, 3'd2, 0, 0, 0, 1, 1, 3'd2, 0, 1, 0, "t3_unmask");
    add(1, 3'd2, 0, 0, 0, 1, 1, 3'd2, 0, 1, 1, "t3_ack");
    add(0, 3'd2, 0, 0, 0, 1, 1, 3'd2, 0, 0, 0, "t3_release");
    // Each activity source blocks the drain; then abort before the window fills.
    add(1, 3'd6, 0, 1, 0, 1, 20, 3'd2, 0, 1, 0, "burst_block");
    add(1, 3'd6, 0, 0, 1, 1, 20, 3'd2, 0, 1, 0, "wslip_block");
    add(1, 3'd6, 0, 0, 0, 0, 20, 3'd2, 0, 1, 0, "empty_block");
    add(1, 3'd1, 0, 0, 0, 1, 7, 3'd2, 0, 1, 0, "partial_quiet");
    add(0, 3'd1, 0, 0, 0, 1, 1, 3'd2, 0, 0, 0, "abort");
    add(0, 3'd1, 0, 0, 0, 1, 10, 3'd2, 0, 0, 0, "after_abort");

    rst = 1'b1;
    cfg_if.cfg_req = 1'b0;
    cfg_if.cfg_num_stages = 3'd0;
    tx_frame_raw = 1'b0; burst_en_exe_raw = 1'b0; wordslip_exe_raw = 1'b0; rd_empty_raw = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    check_outs("reset", 3'd0, 0, 0, 0);
    check("reset_timeout", 16'(cfg_if.cfg_timeout), 16'd0);
    check("reset_state", 16'(state_dbg), 16'd0);

    foreach (tbl[i]) begin
      cfg_if.cfg_req        = tbl[i].req;
      cfg_if.cfg_num_stages = tbl[i].nst;
      tx_frame_raw          = tbl[i].frame;
      burst_en_exe_raw      = tbl[i].burst;
      wordslip_exe_raw      = tbl[i].wslip;
      rd_empty_raw          = tbl[i].empty;
      step(tbl[i].cyc);
      check_outs(tbl[i].name, tbl[i].e_num, tbl[i].e_mask, tbl[i].e_busy, tbl[i].e_ack);
    end

    // Reset in the middle of SETTLE loses the change.
    cfg_if.cfg_req = 1'b1;
    cfg_if.cfg_num_stages = 3'd7;
    step(12);
    check_outs("rst_pre", 3'd7, 1, 1, 0);
    check("rst_pre_state", 16'(state_dbg), 16'd3);
    rst = 1'b1;
    cfg_if.cfg_req = 1'b0;
    step(1);
    rst = 1'b0;
    check_outs("rst_settle", 3'd0, 0, 0, 0);
    check("rst_settle_state", 16'(state_dbg), 16'd0);
    step(3);
    check_outs("rst_idle", 3'd0, 0, 0, 0);

`ifdef HDPLDADAPT_TX_STRETCH_CTRL_TIMEOUT_EN
    // Never empty: forced apply after 256 drain cycles, sticky timeout.
    cfg_if.cfg_req = 1'b1;
    cfg_if.cfg_num_stages = 3'd3;
    rd_empty_raw = 1'b0;
    step(256);
    check_outs("to_wait", 3'd0, 0, 1, 0);
    check("to_wait_flag", 16'(cfg_if.cfg_timeout), 16'd0);
    step(1);
    check("to_flag", 16'(cfg_if.cfg_timeout), 16'd1);
    check("to_flag_num", 16'(num_stages), 16'd0);
    step(1);
    check_outs("to_apply", 3'd3, 1, 1, 0);
    rd_empty_raw = 1'b1;
    step(9);
    check_outs("to_ack", 3'd3, 0, 1, 1);
    cfg_if.cfg_req = 1'b0;
    step(5);
    check_outs("to_release", 3'd3, 0, 0, 0);
    check("to_sticky", 16'(cfg_if.cfg_timeout), 16'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("to_cleared", 16'(cfg_if.cfg_timeout), 16'd0);
`else
    // Without the timeout, a blocked drain waits indefinitely.
    cfg_if.cfg_req = 1'b1;
    cfg_if.cfg_num_stages = 3'd3;
    rd_empty_raw = 1'b0;
    step(300);
    check_outs("no_to_wait", 3'd0, 0, 1, 0);
    check("no_to_flag", 16'(cfg_if.cfg_timeout), 16'd0);
    cfg_if.cfg_req = 1'b0;
    rd_empty_raw = 1'b1;
    step(2);
    check_outs("no_to_abort", 3'd0, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
